// File: rtl/button_event_decoder_if.sv
// Push-button event bus: debouncer pulses in, gesture event pulses out.
// The decoder takes the slave side, whoever feeds it takes the master side.
interface button_event_decoder_if;
  logic pb_down;
  logic pb_up;
  logic pb_state;
  logic short_press;
  logic long_press;
  logic double_press;
  logic repeat_tick;
  logic busy;

  modport master (
    output pb_down, pb_up, pb_state,
    input  short_press, long_press, double_press,
    input  repeat_tick, busy
  );

  modport slave (
    input  pb_down, pb_up, pb_state,
    output short_press, long_press, double_press,
    output repeat_tick, busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into short/long/double press pulses.
// Define AUTO_REPEAT_EN for repeat_tick pulses while a long press is held.
module button_event_decoder #(
  parameter int CNT_W      = 26,
  parameter int LONG_CNT   = 50_000_000,
  parameter int GAP_CNT    = 15_000_000,
  parameter int REPEAT_CNT = 10_000_000
) (
  input logic                  clk,
  input logic                  rst,
  button_event_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    GAP,
    DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CNT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             busy_q;
  logic             rel;
  logic             press;

  // pb_up outranks a simultaneous pb_down everywhere
  assign rel   = bus.pb_up || !bus.pb_state;
  assign press = bus.pb_down && !bus.pb_up;

  always_comb begin
    state_d = state_q;
    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (rel) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_M1) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (rel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (press) begin
          state_d = DRAIN;
          cnt_d   = '0;
          dbl_d   = 1'b1;
        end else if (cnt_q == GAP_M1) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end
      end
      DRAIN: begin
        if (rel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_M1 = CNT_W'(REPEAT_CNT - 1);

  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             tick_q, tick_d;

  // Counter only runs while staying in LONG_HELD; clears on entry and exit
  always_comb begin
    rcnt_d = '0;
    tick_d = 1'b0;
    if (state_q == LONG_HELD && state_d == LONG_HELD) begin
      if (rcnt_q == REP_M1) begin
        tick_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      tick_q <= tick_d;
    end
  end

  assign bus.repeat_tick = tick_q;
`else
  assign bus.repeat_tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = dbl_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed gesture scenarios for button_event_decoder, small parameters.
// Each scenario logs events per cycle, then checks counts and cycles.
module tb_button_event_decoder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .CNT_W     (8),
    .LONG_CNT  (20),
    .GAP_CNT   (10),
    .REPEAT_CNT(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_s, f_s, l_s;
  int n_l, f_l;
  int n_d, f_d;
  int n_t, f_t, l_t;
  int n_busy, multi;
  bit busy_a [0:127];

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one gesture; cycle c outputs are sampled before cycle c inputs.
  task automatic play(input int d0, input int u0, input int d1,
                      input int u1, input int n, input bit rs);
    int ev;
    n_s = 0; f_s = -1; l_s = -1;
    n_l = 0; f_l = -1;
    n_d = 0; f_d = -1;
    n_t = 0; f_t = -1; l_t = -1;
    n_busy = 0; multi = 0;
    for (int c = 0; c < n; c++) begin
      ev = 0;
      if (bus.short_press === 1'b1) begin
        n_s++; ev++; l_s = c;
        if (f_s < 0) f_s = c;
      end
      if (bus.long_press === 1'b1) begin
        n_l++; ev++;
        if (f_l < 0) f_l = c;
      end
      if (bus.double_press === 1'b1) begin
        n_d++; ev++;
        if (f_d < 0) f_d = c;
      end
      if (bus.repeat_tick === 1'b1) begin
        n_t++; ev++; l_t = c;
        if (f_t < 0) f_t = c;
      end
      if (ev > 1) multi++;
      busy_a[c] = (bus.busy === 1'b1);
      if (bus.busy === 1'b1) n_busy++;
      bus.pb_down  = (d0 >= 0 && c == d0) || (d1 >= 0 && c == d1);
      bus.pb_up    = (!rs && u0 >= 0 && c == u0) || (u1 >= 0 && c == u1);
      bus.pb_state = (d0 >= 0 && c >= d0 && (u0 < 0 || c < u0)) ||
                     (d1 >= 0 && c >= d1 && (u1 < 0 || c < u1));
      @(posedge clk);
      #1;
    end
    bus.pb_down  = 1'b0;
    bus.pb_up    = 1'b0;
    bus.pb_state = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.pb_down  = 1'b0;
    bus.pb_up    = 1'b0;
    bus.pb_state = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({bus.short_press, bus.long_press,
        bus.double_press, bus.repeat_tick, bus.busy}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    play(0, 5, -1, -1, 30, 1'b0);
    chk("short_count", n_s, 1);
    chk("short_cycle", f_s, 16);
    chk("short_busy15", int'(busy_a[15]), 1);
    chk("short_busy16", int'(busy_a[16]), 0);
    chk("short_no_long", n_l, 0);
    chk("short_no_dbl", n_d, 0);

    play(0, 40, -1, -1, 60, 1'b0);
    chk("long_count", n_l, 1);
    chk("long_cycle", f_l, 21);
    chk("long_no_short", n_s, 0);
    chk("long_no_dbl", n_d, 0);
    chk("long_busy40", int'(busy_a[40]), 1);
    chk("long_busy41", int'(busy_a[41]), 0);
`ifdef AUTO_REPEAT_EN
    chk("tick_count", n_t, 3);
    chk("tick_first", f_t, 26);
    chk("tick_last", l_t, 36);
`else
    chk("tick_count", n_t, 0);
`endif
    chk("long_exclusive", multi, 0);

    play(0, 3, 8, 50, 60, 1'b0);
    chk("dbl_count", n_d, 1);
    chk("dbl_cycle", f_d, 9);
    chk("dbl_no_short", n_s, 0);
    chk("dbl_no_long", n_l, 0);
    chk("dbl_busy50", int'(busy_a[50]), 1);
    chk("dbl_busy51", int'(busy_a[51]), 0);

    play(0, 3, 14, 17, 40, 1'b0);
    chk("late_short_count", n_s, 2);
    chk("late_short_first", f_s, 14);
    chk("late_short_second", l_s, 28);
    chk("late_no_dbl", n_d, 0);

    play(0, 20, -1, -1, 45, 1'b0);
    chk("coinc_no_long", n_l, 0);
    chk("coinc_short_count", n_s, 1);
    chk("coinc_short_cycle", f_s, 31);

    play(0, 30, -1, -1, 45, 1'b1);
    chk("resync_long", f_l, 21);
    chk("resync_busy30", int'(busy_a[30]), 1);
    chk("resync_busy31", int'(busy_a[31]), 0);
    chk("resync_no_short", n_s, 0);

    play(0, 5, -1, -1, 8, 1'b0);
    chk("rst_pre_busy", int'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", int'({bus.short_press, bus.long_press,
        bus.double_press, bus.repeat_tick, bus.busy}), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    play(-1, -1, -1, -1, 30, 1'b0);
    chk("rst_no_short", n_s, 0);
    chk("rst_no_busy", n_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
